// File: rtl/mul_div_unit_pkg.sv
// Shared constants, types and helpers for the RV32M multiply/divide unit.
package mul_div_unit_pkg;

  localparam int unsigned MD_XLEN  = 32;
  localparam int unsigned MD_CNT_W = 6;

  // RV32M funct3 encodings
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Context of the in-flight instruction
  typedef struct packed {
    logic [2:0] funct3;
    logic [4:0] rd;
  } md_tag_t;

  // rs1 is interpreted as signed
  function automatic logic md_a_signed(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

  // rs2 is interpreted as signed
  function automatic logic md_b_signed(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract divisor.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_bit,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem_c,
  output logic            o_q_bit_c
);

  // Shifted remainder needs one extra bit before the subtract
  logic [XLEN:0] w_shifted;

  assign w_shifted = {i_rem, i_bit};
  assign o_q_bit_c = (w_shifted >= {1'b0, i_divisor});
  assign o_rem_c   = o_q_bit_c ? XLEN'(w_shifted - {1'b0, i_divisor}) : w_shifted[XLEN-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit; one bit per cycle in CALC.
// Optional: define YU_FAST_MUL_EN for single-cycle multiplies via a combinational multiplier.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned XLEN  = MD_XLEN,
  parameter int unsigned CNT_W = MD_CNT_W
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  input  logic [4:0]      desRegisterIn,
  input  logic            kill,
  output logic            busy,
  output logic            resultValid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      desRegisterOut
);

  localparam logic [XLEN-1:0] W_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         r_state,   w_state_nxt;
  md_tag_t           r_tag,     w_tag_nxt;
  logic [XLEN-1:0]   r_a_mag,   w_a_mag_nxt;
  logic [XLEN-1:0]   r_b_mag,   w_b_mag_nxt;
  logic              r_neg_res, w_neg_res_nxt;
  logic              r_neg_rem, w_neg_rem_nxt;
  logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
  logic [2*XLEN-1:0] r_acc,     w_acc_nxt;
  logic [XLEN-1:0]   r_result,  w_result_nxt;
  logic              r_busy,    w_busy_nxt;
  logic              r_valid,   w_valid_nxt;

  logic              w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div_ovf;
  logic [XLEN-1:0]   w_mul_addend;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_step;
  logic [XLEN-1:0]   w_div_rem;
  logic              w_div_q;
  logic [2*XLEN-1:0] w_div_step;
  logic [2*XLEN-1:0] w_acc_step;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot, w_rem;
  logic [XLEN-1:0]   w_fix;

  // Operand sign handling at issue
  assign w_a_neg   = md_a_signed(funct3) & operandA[XLEN-1];
  assign w_b_neg   = md_b_signed(funct3) & operandB[XLEN-1];
  assign w_a_mag   = w_a_neg ? -operandA : operandA;
  assign w_b_mag   = w_b_neg ? -operandB : operandB;
  assign w_div_ovf = ((funct3 == MD_DIV) || (funct3 == MD_REM)) &&
                     (operandA == W_INT_MIN) && (&operandB);

  // Shift-add multiply step: acc = {partial product, remaining multiplier bits}
  assign w_mul_addend = r_acc[0] ? r_a_mag : {XLEN{1'b0}};
  assign w_mul_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_mul_addend};
  assign w_mul_step   = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring divide step: acc = {remainder, dividend/quotient}
  div_step #(.XLEN(XLEN)) u_div_step (
    .i_rem     (r_acc[2*XLEN-1:XLEN]),
    .i_bit     (r_acc[XLEN-1]),
    .i_divisor (r_b_mag),
    .o_rem_c   (w_div_rem),
    .o_q_bit_c (w_div_q)
  );
  assign w_div_step = {w_div_rem, r_acc[XLEN-2:0], w_div_q};

  assign w_acc_step = r_tag.funct3[2] ? w_div_step : w_mul_step;

  // Sign fix-up applied to the final iteration's value
  assign w_prod = r_neg_res ? -w_acc_step : w_acc_step;
  assign w_quot = r_neg_res ? -w_acc_step[XLEN-1:0] : w_acc_step[XLEN-1:0];
  assign w_rem  = r_neg_rem ? -w_acc_step[2*XLEN-1:XLEN] : w_acc_step[2*XLEN-1:XLEN];

  // Result word select by operation
  always_comb begin
    w_fix = w_rem;
    case (r_tag.funct3)
      MD_MUL:                       w_fix = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_fix = w_quot;
      MD_REM, MD_REMU:              w_fix = w_rem;
      default:                      w_fix = w_rem;
    endcase
  end

`ifdef YU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_a, w_fast_b, w_fast_prod;
  logic [XLEN-1:0]   w_fast_sel;

  // Single-cycle product on sign/zero-extended operands
  assign w_fast_a    = {{XLEN{w_a_neg}}, operandA};
  assign w_fast_b    = {{XLEN{w_b_neg}}, operandB};
  assign w_fast_prod = w_fast_a * w_fast_b;
  assign w_fast_sel  = (funct3 == MD_MUL) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
`endif

  // Next-state and datapath update
  always_comb begin
    w_state_nxt   = r_state;
    w_tag_nxt     = r_tag;
    w_a_mag_nxt   = r_a_mag;
    w_b_mag_nxt   = r_b_mag;
    w_neg_res_nxt = r_neg_res;
    w_neg_rem_nxt = r_neg_rem;
    w_cnt_nxt     = r_cnt;
    w_acc_nxt     = r_acc;
    w_result_nxt  = r_result;

    case (r_state)
      MD_IDLE: begin
        if (start) begin
          w_tag_nxt.funct3 = funct3;
          w_tag_nxt.rd     = desRegisterIn;
          w_a_mag_nxt      = w_a_mag;
          w_b_mag_nxt      = w_b_mag;
          w_neg_res_nxt    = w_a_neg ^ w_b_neg;
          w_neg_rem_nxt    = w_a_neg;
          w_cnt_nxt        = '0;
          if (funct3[2]) begin
            w_acc_nxt = {{XLEN{1'b0}}, w_a_mag};
            if (operandB == {XLEN{1'b0}}) begin
              w_result_nxt = funct3[1] ? operandA : {XLEN{1'b1}};
              w_state_nxt  = MD_DONE;
            end else if (w_div_ovf) begin
              w_result_nxt = funct3[1] ? {XLEN{1'b0}} : W_INT_MIN;
              w_state_nxt  = MD_DONE;
            end else begin
              w_state_nxt  = MD_CALC;
            end
          end else begin
            w_acc_nxt = {{XLEN{1'b0}}, w_b_mag};
`ifdef YU_FAST_MUL_EN
            w_result_nxt = w_fast_sel;
            w_state_nxt  = MD_DONE;
`else
            w_state_nxt  = MD_CALC;
`endif
          end
        end
      end
      MD_CALC: begin
        w_acc_nxt = w_acc_step;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(XLEN - 1)) begin
          w_result_nxt = w_fix;
          w_state_nxt  = MD_DONE;
        end
        if (kill) begin
          w_state_nxt = MD_IDLE;
        end
      end
      MD_DONE: begin
        w_state_nxt = MD_IDLE;
      end
      default: begin
        w_state_nxt = MD_IDLE;
      end
    endcase

    w_busy_nxt  = (w_state_nxt != MD_IDLE);
    w_valid_nxt = (w_state_nxt == MD_DONE);
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state   <= MD_IDLE;
      r_tag     <= '0;
      r_a_mag   <= '0;
      r_b_mag   <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tag     <= w_tag_nxt;
      r_a_mag   <= w_a_mag_nxt;
      r_b_mag   <= w_b_mag_nxt;
      r_neg_res <= w_neg_res_nxt;
      r_neg_rem <= w_neg_rem_nxt;
      r_cnt     <= w_cnt_nxt;
      r_acc     <= w_acc_nxt;
      r_result  <= w_result_nxt;
      r_busy    <= w_busy_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  assign busy           = r_busy;
  assign resultValid    = r_valid;
  assign result         = r_result;
  assign desRegisterOut = r_tag.rd;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit.
module tb_mul_div_unit;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam int DIV_CYC = 33;
`ifdef YU_FAST_MUL_EN
  localparam int MUL_CYC = 1;
`else
  localparam int MUL_CYC = 33;
`endif

  logic        clk;
  logic        resetN;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [4:0]  desRegisterIn;
  logic        kill;
  logic        busy;
  logic        resultValid;
  logic [31:0] result;
  logic [4:0]  desRegisterOut;

  int n_cmp = 0;
  int n_err = 0;

  mul_div_unit dut (
    .clk            (clk),
    .resetN         (resetN),
    .start          (start),
    .funct3         (funct3),
    .operandA       (operandA),
    .operandB       (operandB),
    .desRegisterIn  (desRegisterIn),
    .kill           (kill),
    .busy           (busy),
    .resultValid    (resultValid),
    .result         (result),
    .desRegisterOut (desRegisterOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present an op at a negedge so it is sampled at the next posedge (E0)
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; funct3 = f3; operandA = a; operandB = b; desRegisterIn = rd;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy cycles until the resultValid pulse, then check it lasts one cycle
  task automatic wait_result(input string tag, input logic [31:0] exp_res,
                             input logic [4:0] exp_rd, input int exp_cyc);
    int          cyc;
    bit          seen;
    logic [31:0] res;
    logic [4:0]  rd;
    cyc = 0; seen = 1'b0; res = '0; rd = '0;
    for (int i = 0; i < 200; i++) begin
      if (busy) cyc++;
      if (resultValid) begin
        seen = 1'b1; res = result; rd = desRegisterOut;
        break;
      end
      @(negedge clk);
    end
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check_eq({tag, "_res"}, res, exp_res);
      check_eq({tag, "_rd"}, 32'(rd), 32'(exp_rd));
      check_eq({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
      @(negedge clk);
      check_eq({tag, "_after"}, {30'd0, busy, resultValid}, 32'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_cyc);
    issue(f3, a, b, rd);
    wait_result(tag, exp_res, rd, exp_cyc);
  endtask

  // Watch for a number of cycles; any resultValid pulse is an error
  task automatic watch_no_valid(input string tag, input int ncyc);
    int pulses;
    pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (resultValid) pulses++;
    end
    check_eq({tag, "_pulses"}, 32'(pulses), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    resetN = 1'b0; start = 1'b0; funct3 = '0; operandA = '0; operandB = '0;
    desRegisterIn = '0; kill = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_valid", 32'(resultValid), 32'd0);
    check_eq("rst_res",   result, 32'd0);
    check_eq("rst_rd",    32'(desRegisterOut), 32'd0);
    resetN = 1'b1;

    // Multiplies
    run_op("mul_7_m3",    F_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_CYC);
    run_op("mulhu_m1",    F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, MUL_CYC);
    run_op("mulh_m1",     F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, MUL_CYC);
    run_op("mulhsu_m1_2", F_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd8, 32'hFFFF_FFFF, MUL_CYC);
    run_op("mul_2p32",    F_MUL,    32'h0001_0000, 32'h0001_0000, 5'd9, 32'h0000_0000, MUL_CYC);
    run_op("mulhu_2p32",  F_MULHU,  32'h0001_0000, 32'h0001_0000, 5'd10, 32'h0000_0001, MUL_CYC);

    // Divide fast paths
    run_op("div_ovf",     F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    run_op("rem_ovf",     F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 1);
    run_op("divu_by0",    F_DIVU, 32'd123,       32'd0,         5'd13, 32'hFFFF_FFFF, 1);
    run_op("remu_by0",    F_REMU, 32'd123,       32'd0,         5'd14, 32'd123,       1);
    run_op("div_by0",     F_DIV,  32'hFFFF_FFFB, 32'd0,         5'd15, 32'hFFFF_FFFF, 1);
    run_op("rem_by0",     F_REM,  32'hFFFF_FFFB, 32'd0,         5'd16, 32'hFFFF_FFFB, 1);

    // Iterative divides
    run_op("rem_m7_2",    F_REM,  32'hFFFF_FFF9, 32'd2,         5'd17, 32'hFFFF_FFFF, DIV_CYC);
    run_op("div_m7_2",    F_DIV,  32'hFFFF_FFF9, 32'd2,         5'd18, 32'hFFFF_FFFD, DIV_CYC);
    run_op("divu_100_7",  F_DIVU, 32'd100,       32'd7,         5'd19, 32'd14,        DIV_CYC);
    run_op("remu_100_7",  F_REMU, 32'd100,       32'd7,         5'd20, 32'd2,         DIV_CYC);
    run_op("div_20_m3",   F_DIV,  32'd20,        32'hFFFF_FFFD, 5'd0,  32'hFFFF_FFFA, DIV_CYC);
    run_op("rem_20_m3",   F_REM,  32'd20,        32'hFFFF_FFFD, 5'd21, 32'd2,         DIV_CYC);

    // Reset during CALC cycle 10
    issue(F_DIVU, 32'd100, 32'd7, 5'd22);
    repeat (9) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    check_eq("rstab_busy", 32'(busy), 32'd0);
    check_eq("rstab_res",  result, 32'd0);
    check_eq("rstab_rd",   32'(desRegisterOut), 32'd0);
    resetN = 1'b1;
    watch_no_valid("rstab", 40);

    // Kill during CALC cycle 10
    issue(F_DIVU, 32'd100, 32'd7, 5'd23);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check_eq("kill_busy", 32'(busy), 32'd0);
    watch_no_valid("kill", 40);

    // Kill held in IDLE alongside start does not block the issue
    @(negedge clk);
    kill = 1'b1;
    issue(F_DIVU, 32'd100, 32'd7, 5'd24);
    kill = 1'b0;
    wait_result("kill_idle", 32'd14, 5'd24, DIV_CYC);

    // Second start while busy is dropped
    issue(F_DIVU, 32'd100, 32'd7, 5'd3);
    repeat (4) @(negedge clk);
    start = 1'b1; funct3 = F_MUL; operandA = 32'd3; operandB = 32'd3; desRegisterIn = 5'd9;
    @(negedge clk);
    start = 1'b0;
    wait_result("ignored", 32'd14, 5'd3, DIV_CYC - 5);
    watch_no_valid("noqueue", 5);

    // Normal operation afterwards
    run_op("after_mul",   F_MUL,  32'd6, 32'd7, 5'd31, 32'd42, MUL_CYC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
